// File: rtl/control_unit_pipe_if.sv
// rtl/control_unit_pipe_if.sv - ID/EX control bus between the pipeline datapath and the decode stage
interface control_unit_pipe_if #(
  parameter int CHW = 2
);
  logic [31:0]    instr_ID;
  logic           valid_ID;
  logic           stall_in;
  logic           zero_EX;
  logic [3:0]     alu_op_EX;
  logic [4:0]     shamt_EX;
  logic           enhilo_EX;
  logic [1:0]     regsel_EX;
  logic           regwrite_EX;
  logic           rdrt_EX;
  logic           memwrite_EX;
  logic [1:0]     alu_src_EX;
  logic           gpio_out_EX;
  logic           gpio_in_EX;
  logic [CHW-1:0] gpio_ch_EX;
  logic [1:0]     pc_src_EX;
  logic           flush_ID;
  logic           stall_ID;
  logic           illegal_EX;

  modport master (
    output instr_ID, valid_ID, stall_in, zero_EX,
    input  alu_op_EX, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX,
           memwrite_EX, alu_src_EX, gpio_out_EX, gpio_in_EX, gpio_ch_EX,
           pc_src_EX, flush_ID, stall_ID, illegal_EX
  );

  modport slave (
    input  instr_ID, valid_ID, stall_in, zero_EX,
    output alu_op_EX, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX,
           memwrite_EX, alu_src_EX, gpio_out_EX, gpio_in_EX, gpio_ch_EX,
           pc_src_EX, flush_ID, stall_ID, illegal_EX
  );
endinterface

// File: rtl/control_unit_pipe.sv
// rtl/control_unit_pipe.sv - registered ID decode into the EX control bundle
// Resolves beq/bne/j in EX and holds dependent HI/LO instructions while a multiply is busy.
module control_unit_pipe #(
  parameter int MULT_LAT = 4,
  parameter int GPIO_CH  = 4,
  parameter int CHW      = (GPIO_CH > 1) ? $clog2(GPIO_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  control_unit_pipe_if.slave bus
);

  typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE, BR_JUMP} br_e;

  typedef struct packed {
    logic [3:0]     alu_op;
    logic [4:0]     shamt;
    logic           enhilo;
    logic [1:0]     regsel;
    logic           regwrite;
    logic           rdrt;
    logic           memwrite;
    logic [1:0]     alu_src;
    logic           gpio_out;
    logic           gpio_in;
    logic [CHW-1:0] gpio_ch;
    br_e            br;
    logic           illegal;
  } ctrl_t;

  ctrl_t      ex_q, ex_d, dec;
  logic [3:0] cnt_q, cnt_d;
  logic       dec_bad;
  logic       gpio_rs_bad;
  logic       hilo_instr;
  logic       flush;
  logic       stall_id;
  logic [1:0] pc_src;
  logic [5:0] op, funct;
  logic [4:0] rs, sh;

  assign op          = bus.instr_ID[31:26];
  assign funct       = bus.instr_ID[5:0];
  assign rs          = bus.instr_ID[25:21];
  assign sh          = bus.instr_ID[10:6];
  assign gpio_rs_bad = (32'(rs) >= 32'(GPIO_CH));

  always_comb begin
    dec     = '0;
    dec_bad = 1'b0;
    if (op == 6'h00) begin
      case (funct)
        6'h00: if (bus.instr_ID != 32'd0) begin
          dec.alu_op   = 4'b1000;
          dec.shamt    = sh;
          dec.regwrite = 1'b1;
        end
        // Zero-shift srl/sra are repurposed as GPIO write/read on channel rs.
        6'h02: begin
          dec.alu_op = 4'b1001;
          dec.shamt  = sh;
          if (sh == 5'd0) begin
            dec.gpio_out = 1'b1;
            dec.gpio_ch  = rs[CHW-1:0];
            dec_bad      = gpio_rs_bad;
          end else begin
            dec.regwrite = 1'b1;
          end
        end
        6'h03: begin
          dec.alu_op   = 4'b1010;
          dec.shamt    = sh;
          dec.regwrite = 1'b1;
          if (sh == 5'd0) begin
            dec.gpio_in = 1'b1;
            dec.gpio_ch = rs[CHW-1:0];
            dec_bad     = gpio_rs_bad;
          end
        end
        6'h20, 6'h21: begin dec.alu_op = 4'b0100; dec.regwrite = 1'b1; end
        6'h22, 6'h23: begin dec.alu_op = 4'b0101; dec.regwrite = 1'b1; end
        6'h24: begin dec.alu_op = 4'b0000; dec.regwrite = 1'b1; end
        6'h25: begin dec.alu_op = 4'b0001; dec.regwrite = 1'b1; end
        6'h27: begin dec.alu_op = 4'b0010; dec.regwrite = 1'b1; end
        6'h26: begin dec.alu_op = 4'b0011; dec.regwrite = 1'b1; end
        6'h2A: begin dec.alu_op = 4'b1100; dec.regwrite = 1'b1; end
        6'h2B: begin dec.alu_op = 4'b1101; dec.regwrite = 1'b1; end
        6'h18: begin dec.alu_op = 4'b0110; dec.enhilo = 1'b1; end
        6'h19: begin dec.alu_op = 4'b0111; dec.enhilo = 1'b1; end
        6'h10: begin dec.regsel = 2'd1; dec.regwrite = 1'b1; end
        6'h12: begin dec.regsel = 2'd2; dec.regwrite = 1'b1; end
        default: dec_bad = 1'b1;
      endcase
    end else begin
      dec.rdrt     = 1'b1;
      dec.regwrite = 1'b1;
      case (op)
        6'h0F: begin dec.alu_op = 4'b1000; dec.shamt = 5'd16; end
        6'h08, 6'h09: begin dec.alu_op = 4'b0100; dec.alu_src = 2'd1; end
        6'h0C: begin dec.alu_op = 4'b0000; dec.alu_src = 2'd2; end
        6'h0D: begin dec.alu_op = 4'b0001; dec.alu_src = 2'd2; end
        6'h0E: begin dec.alu_op = 4'b0011; dec.alu_src = 2'd2; end
        6'h0A: begin dec.alu_op = 4'b1100; dec.alu_src = 2'd1; end
        6'h04, 6'h05: begin
          dec.rdrt     = 1'b0;
          dec.regwrite = 1'b0;
          dec.alu_op   = 4'b0101;
          dec.br       = (op == 6'h04) ? BR_EQ : BR_NE;
        end
        6'h02: begin
          dec.rdrt     = 1'b0;
          dec.regwrite = 1'b0;
          dec.br       = BR_JUMP;
        end
        default: dec_bad = 1'b1;
      endcase
    end
    if (dec_bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  always_comb begin
    pc_src = 2'd0;
    if (!bus.stall_in) begin
      case (ex_q.br)
        BR_EQ:   if (bus.zero_EX)  pc_src = 2'd1;
        BR_NE:   if (!bus.zero_EX) pc_src = 2'd1;
        BR_JUMP: pc_src = 2'd2;
        default: pc_src = 2'd0;
      endcase
    end
  end

  assign flush      = (pc_src != 2'd0);
  assign hilo_instr = (op == 6'h00) &&
                      (funct == 6'h18 || funct == 6'h19 || funct == 6'h10 || funct == 6'h12);
  assign stall_id   = bus.valid_ID && hilo_instr && (cnt_q != 4'd0) && !flush;

  // The busy counter runs down even under stall_in so HI/LO timing tracks real cycles.
  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
    if (!bus.stall_in) begin
      if (flush || stall_id || !bus.valid_ID) begin
        ex_d = '0;
      end else begin
        ex_d = dec;
        if (dec.enhilo) cnt_d = 4'(MULT_LAT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      cnt_q <= 4'd0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.alu_op_EX   = ex_q.alu_op;
  assign bus.shamt_EX    = ex_q.shamt;
  assign bus.enhilo_EX   = ex_q.enhilo;
  assign bus.regsel_EX   = ex_q.regsel;
  assign bus.regwrite_EX = ex_q.regwrite;
  assign bus.rdrt_EX     = ex_q.rdrt;
  assign bus.memwrite_EX = ex_q.memwrite;
  assign bus.alu_src_EX  = ex_q.alu_src;
  assign bus.gpio_out_EX = ex_q.gpio_out;
  assign bus.gpio_in_EX  = ex_q.gpio_in;
  assign bus.gpio_ch_EX  = ex_q.gpio_ch;
  assign bus.illegal_EX  = ex_q.illegal;
  assign bus.pc_src_EX   = pc_src;
  assign bus.flush_ID    = flush;
  assign bus.stall_ID    = stall_id;

endmodule
